// File: rtl/relu_maxpool_2x2.sv
// -----------------------------------------------------------------------------
// relu_maxpool_2x2
//
// Streaming ReLU followed by 2x2 / stride-2 max pooling on a raster-order
// feature map of D x D IEEE-754 single-precision pixels. No floating-point
// arithmetic is used. After ReLU every value is non-negative, so an unsigned
// integer compare of the bit patterns orders the values correctly. Positive
// NaN and +Inf therefore win every compare.
//
// Dataflow per 2x2 window:
//   even row, even col : h      <= relu(px)
//   even row, odd col  : lb[c/2] <= max(h, relu(px))
//   odd row,  even col : h      <= max(lb[c/2], relu(px))
//   odd row,  odd col  : pxl_out <= max(h, relu(px)), valid_out pulses
// With an odd D, the last column and the last row only advance the counters.
//
// Ports:
//   clk        in   rising-edge clock
//   reset      in   asynchronous, active-high reset
//   valid_in   in   pxl_in is a valid raster-order pixel this cycle
//   pxl_in     in   input pixel (data_width bits, IEEE-754 float)
//   pxl_out    out  pooled pixel; holds its last value between pulses
//   valid_out  out  one-cycle pulse, pxl_out valid
//   frame_end  out  one-cycle pulse with the last pooled pixel of a frame
// -----------------------------------------------------------------------------
module relu_maxpool_2x2 #(
    parameter int D          = 24,
    parameter int data_width = 32
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  valid_in,
    input  logic [data_width-1:0] pxl_in,
    output logic [data_width-1:0] pxl_out,
    output logic                  valid_out,
    output logic                  frame_end
);

    localparam int HALF = D / 2;
    localparam int CW   = (D > 1) ? $clog2(D) : 1;
    localparam int IW   = (HALF > 1) ? $clog2(HALF) : 1;

    localparam logic [CW-1:0] LAST_IDX = CW'(D - 1);
    localparam logic [CW-1:0] LAST_WIN = CW'(2 * HALF - 1);
    localparam bit            ODD_D    = (D % 2) != 0;

    typedef logic [data_width-1:0] pixel_t;

    function automatic pixel_t relu(input pixel_t x);
        return x[data_width-1] ? '0 : x;
    endfunction

    function automatic pixel_t max_u(input pixel_t a, input pixel_t b);
        return (a > b) ? a : b;
    endfunction

    logic [CW-1:0] col_q, col_d;
    logic [CW-1:0] row_q, row_d;
    pixel_t        h_q, h_d;
    pixel_t        lb_q [HALF];
    pixel_t        pxl_out_q, pxl_out_d;
    logic          valid_out_q, valid_out_d;
    logic          frame_end_q, frame_end_d;

    pixel_t        px;
    pixel_t        pool;
    logic [IW-1:0] lb_idx;
    logic          lb_we;
    logic          in_window;

    assign px     = relu(pxl_in);
    assign pool   = max_u(h_q, px);
    assign lb_idx = IW'(col_q >> 1);

    // The last column/row of an odd-sized map belongs to no window.
    assign in_window = !ODD_D || ((col_q != LAST_IDX) && (row_q != LAST_IDX));

    // NOTE: every signal driven here gets a default first, so no path can
    // leave a value unassigned and infer a latch.
    always_comb begin
        col_d       = col_q;
        row_d       = row_q;
        h_d         = h_q;
        lb_we       = 1'b0;
        pxl_out_d   = pxl_out_q;
        valid_out_d = 1'b0;
        frame_end_d = 1'b0;

        if (valid_in) begin
            if (col_q == LAST_IDX) begin
                col_d = '0;
                row_d = (row_q == LAST_IDX) ? '0 : row_q + 1'b1;
            end else begin
                col_d = col_q + 1'b1;
            end

            if (in_window) begin
                unique case ({row_q[0], col_q[0]})
                    2'b00: h_d   = px;
                    2'b01: lb_we = 1'b1;
                    2'b10: h_d   = max_u(lb_q[lb_idx], px);
                    2'b11: begin
                        pxl_out_d   = pool;
                        valid_out_d = 1'b1;
                        frame_end_d = (row_q == LAST_WIN) && (col_q == LAST_WIN);
                    end
                    default: ;
                endcase
            end
        end
    end

    // NOTE: state registers use non-blocking assignments so every flop
    // samples the pre-edge value of every other flop.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            col_q       <= '0;
            row_q       <= '0;
            pxl_out_q   <= '0;
            valid_out_q <= 1'b0;
            frame_end_q <= 1'b0;
        end else begin
            col_q       <= col_d;
            row_q       <= row_d;
            pxl_out_q   <= pxl_out_d;
            valid_out_q <= valid_out_d;
            frame_end_q <= frame_end_d;
        end
    end

    // NOTE: the hold register and line buffer are not reset; each entry is
    // always written earlier in the frame than it is read, and leaving the
    // memory reset-free lets it map onto plain RAM/flops without a reset net.
    always_ff @(posedge clk) begin
        h_q <= h_d;
        if (lb_we) begin
            lb_q[lb_idx] <= pool;
        end
    end

    assign pxl_out   = pxl_out_q;
    assign valid_out = valid_out_q;
    assign frame_end = frame_end_q;

endmodule

// File: tb/tb_relu_maxpool_2x2.sv
// -----------------------------------------------------------------------------
// tb_relu_maxpool_2x2
//
// Drives three instances (D=4, D=5, D=24) one at a time. The reference model
// stores each frame in a 2D array and, whenever the bottom-right pixel of a
// 2x2 window arrives, computes the window maximum of the ReLU'd pixels. Every
// cycle checks valid_out, frame_end and pxl_out of all three instances.
// -----------------------------------------------------------------------------
module tb_relu_maxpool_2x2;

    logic        clk = 1'b0;
    logic        reset = 1'b0;
    logic        valid_in_a  [3];
    logic [31:0] pxl_in_a    [3];
    logic [31:0] pxl_out_a   [3];
    logic        valid_out_a [3];
    logic        frame_end_a [3];

    always #5 clk = ~clk;

    relu_maxpool_2x2 #(.D(4), .data_width(32)) u_d4 (
        .clk(clk), .reset(reset), .valid_in(valid_in_a[0]), .pxl_in(pxl_in_a[0]),
        .pxl_out(pxl_out_a[0]), .valid_out(valid_out_a[0]), .frame_end(frame_end_a[0])
    );

    relu_maxpool_2x2 #(.D(5), .data_width(32)) u_d5 (
        .clk(clk), .reset(reset), .valid_in(valid_in_a[1]), .pxl_in(pxl_in_a[1]),
        .pxl_out(pxl_out_a[1]), .valid_out(valid_out_a[1]), .frame_end(frame_end_a[1])
    );

    relu_maxpool_2x2 u_d24 (
        .clk(clk), .reset(reset), .valid_in(valid_in_a[2]), .pxl_in(pxl_in_a[2]),
        .pxl_out(pxl_out_a[2]), .valid_out(valid_out_a[2]), .frame_end(frame_end_a[2])
    );

    int n_checks = 0;
    int n_bad    = 0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        n_checks++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s: got %h expected %h", tag, got, exp);
        end
    endtask

    // ---------------- reference model ----------------
    int          mr [3];
    int          mc [3];
    logic [31:0] fr [3][24][24];
    logic [31:0] last_out [3];
    logic        exp_v  [3];
    logic        exp_fe [3];
    logic [31:0] cap4 [$];
    logic [31:0] cap5 [$];

    function automatic int dim(input int k);
        return (k == 0) ? 4 : ((k == 1) ? 5 : 24);
    endfunction

    function automatic logic [31:0] relu_f(input logic [31:0] x);
        return x[31] ? 32'h0 : x;
    endfunction

    function automatic logic [31:0] umax(input logic [31:0] a, input logic [31:0] b);
        return (a > b) ? a : b;
    endfunction

    // Exact float encoding of a small positive integer.
    function automatic logic [31:0] f32(input int n);
        int e = 0;
        logic [31:0] mant;
        while ((1 << (e + 1)) <= n) e++;
        mant = 32'(n - (1 << e)) << (23 - e);
        return (32'(127 + e) << 23) | mant;
    endfunction

    task automatic model_reset();
        for (int k = 0; k < 3; k++) begin
            mr[k] = 0;
            mc[k] = 0;
            last_out[k] = 32'h0;
            exp_v[k] = 1'b0;
            exp_fe[k] = 1'b0;
        end
    endtask

    // One clock cycle on instance k; the others see valid_in low and junk data.
    task automatic cycle(input int k, input logic v, input logic [31:0] px);
        for (int j = 0; j < 3; j++) begin
            valid_in_a[j] = (j == k) && v;
            pxl_in_a[j]   = (j == k) ? px : $urandom();
        end
        @(posedge clk);
        for (int j = 0; j < 3; j++) begin
            exp_v[j]  = 1'b0;
            exp_fe[j] = 1'b0;
        end
        if (v) begin
            int d = dim(k);
            int h = d / 2;
            int r = mr[k];
            int c = mc[k];
            fr[k][r][c] = relu_f(px);
            if ((r % 2 == 1) && (c % 2 == 1) && (r < 2 * h) && (c < 2 * h)) begin
                last_out[k] = umax(umax(fr[k][r-1][c-1], fr[k][r-1][c]),
                                   umax(fr[k][r][c-1],   fr[k][r][c]));
                exp_v[k]  = 1'b1;
                exp_fe[k] = (r == 2 * h - 1) && (c == 2 * h - 1);
            end
            if (c == d - 1) begin
                mc[k] = 0;
                mr[k] = (r == d - 1) ? 0 : r + 1;
            end else begin
                mc[k] = c + 1;
            end
        end
        @(negedge clk);
        for (int j = 0; j < 3; j++) begin
            check($sformatf("d%0d valid_out", dim(j)), 32'(valid_out_a[j]), 32'(exp_v[j]));
            check($sformatf("d%0d frame_end", dim(j)), 32'(frame_end_a[j]), 32'(exp_fe[j]));
            check($sformatf("d%0d pxl_out", dim(j)), pxl_out_a[j], last_out[j]);
        end
        if (valid_out_a[0]) cap4.push_back(pxl_out_a[0]);
        if (valid_out_a[1]) cap5.push_back(pxl_out_a[1]);
    endtask

    task automatic do_reset();
        @(negedge clk);
        for (int j = 0; j < 3; j++) valid_in_a[j] = 1'b0;
        reset = 1'b1;
        #1;
        // Outputs must clear before any clock edge arrives.
        for (int j = 0; j < 3; j++) begin
            check($sformatf("d%0d reset pxl_out", dim(j)), pxl_out_a[j], 32'h0);
            check($sformatf("d%0d reset valid_out", dim(j)), 32'(valid_out_a[j]), 32'h0);
            check($sformatf("d%0d reset frame_end", dim(j)), 32'(frame_end_a[j]), 32'h0);
        end
        model_reset();
        @(posedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    // Pixels 1.0 .. (D*D).0 in raster order, with 'gap' idle cycles after each.
    task automatic ramp_frame(input int k, input int gap);
        for (int n = 1; n <= dim(k) * dim(k); n++) begin
            cycle(k, 1'b1, f32(n));
            for (int g = 0; g < gap; g++) cycle(k, 1'b0, $urandom());
        end
    endtask

    task automatic check_cap4(input string tag, input logic [31:0] e0, input logic [31:0] e1,
                              input logic [31:0] e2, input logic [31:0] e3);
        logic [31:0] exp [4];
        exp = '{e0, e1, e2, e3};
        check({tag, " count"}, 32'(cap4.size()), 32'd4);
        for (int i = 0; i < 4 && i < cap4.size(); i++)
            check($sformatf("%s out%0d", tag, i), cap4[i], exp[i]);
    endtask

    initial begin
        for (int j = 0; j < 3; j++) begin
            valid_in_a[j] = 1'b0;
            pxl_in_a[j]   = 32'h0;
        end
        do_reset();

        // Ramp frame, no gaps.
        cap4.delete();
        ramp_frame(0, 0);
        cycle(0, 1'b0, 32'h0);
        check_cap4("ramp", 32'h40C00000, 32'h41000000, 32'h41600000, 32'h41800000);

        // All -1.0 pixels.
        cap4.delete();
        for (int n = 0; n < 16; n++) cycle(0, 1'b1, 32'hBF800000);
        cycle(0, 1'b0, 32'h0);
        check_cap4("neg", 32'h0, 32'h0, 32'h0, 32'h0);

        // Ramp frame with valid_in every third cycle.
        cap4.delete();
        ramp_frame(0, 2);
        check_cap4("gapped", 32'h40C00000, 32'h41000000, 32'h41600000, 32'h41800000);

        // Reset after five pixels, then a full ramp frame.
        for (int n = 1; n <= 5; n++) cycle(0, 1'b1, f32(n + 20));
        do_reset();
        cap4.delete();
        ramp_frame(0, 0);
        cycle(0, 1'b0, 32'h0);
        check_cap4("midreset", 32'h40C00000, 32'h41000000, 32'h41600000, 32'h41800000);

        // Odd D: two back-to-back ramp frames.
        cap5.delete();
        ramp_frame(1, 0);
        ramp_frame(1, 0);
        cycle(1, 1'b0, 32'h0);
        check("d5 count", 32'(cap5.size()), 32'd8);
        for (int i = 0; i < 8 && i < cap5.size(); i++) begin
            logic [31:0] exp5 [4];
            exp5 = '{32'h40E00000, 32'h41100000, 32'h41880000, 32'h41980000};
            check($sformatf("d5 out%0d", i), cap5[i], exp5[i % 4]);
        end

        // NaN handling in the first window.
        cap4.delete();
        cycle(0, 1'b1, 32'h7FC00000);
        for (int n = 1; n < 16; n++) cycle(0, 1'b1, 32'h3F800000);
        cycle(0, 1'b0, 32'h0);
        check("pos nan first", (cap4.size() > 0) ? cap4[0] : 32'hDEADBEEF, 32'h7FC00000);
        cap4.delete();
        cycle(0, 1'b1, 32'hFFC00000);
        for (int n = 1; n < 16; n++) cycle(0, 1'b1, 32'h3F800000);
        cycle(0, 1'b0, 32'h0);
        check("neg nan first", (cap4.size() > 0) ? cap4[0] : 32'hDEADBEEF, 32'h3F800000);

        // Random pixels with random gaps on every instance.
        for (int k = 0; k < 3; k++) begin
            int frames = (k == 2) ? 2 : 4;
            for (int f = 0; f < frames; f++) begin
                for (int n = 0; n < dim(k) * dim(k); n++) begin
                    cycle(k, 1'b1, $urandom());
                    if ($urandom_range(0, 3) == 0) cycle(k, 1'b0, $urandom());
                end
            end
        end

        // Random partial frame, reset, then random full frames.
        for (int n = 0; n < 7; n++) cycle(1, 1'b1, $urandom());
        do_reset();
        for (int f = 0; f < 2; f++)
            for (int n = 0; n < 25; n++) cycle(1, 1'b1, $urandom());
        cycle(1, 1'b0, 32'h0);

        $display("test done: total=%0d bad=%0d", n_checks, n_bad);
        $finish;
    end

endmodule

// File: doc/relu_maxpool_2x2.md
RELU_MAXPOOL_2X2 -- requirements
Module: relu_maxpool_2x2

Interface
REQ-001 The block SHALL have parameter D, default 24, giving the input feature-map side length in pixels (the stride-2 3x3 conv output for a 49x49 input).
REQ-002 The block SHALL have parameter data_width, default 32, giving the IEEE-754 single-precision pixel width.
REQ-003 The block SHALL have one clock and an asynchronous active-high reset.
REQ-004 Port: clk  input  1  rising-edge clock.
REQ-005 Port: reset  input  1  asynchronous, active-high reset.
REQ-006 Port: valid_in  input  1  pxl_in is a valid raster-order pixel this cycle.
REQ-007 Port: pxl_in  input  data_width  input pixel, IEEE-754 float.
REQ-008 Port: pxl_out  output  data_width  pooled pixel, IEEE-754 float.
REQ-009 Port: valid_out  output  1  one-cycle pulse; pxl_out is valid.
REQ-010 Port: frame_end  output  1  one-cycle pulse coincident with the last pooled pixel of a frame.

Function
REQ-011 ReLU SHALL map any input with sign bit 1 (including -0.0 and negative NaN) to 32'h00000000; other inputs pass unchanged.
REQ-012 Max comparisons SHALL be unsigned integer compares of post-ReLU bit patterns, so positive NaN/Inf win, with no floating-point unit.
REQ-013 Column counter col (0..D-1) and row counter row (0..D-1) SHALL advance only on valid_in: col wraps D-1->0 and increments row; row wraps D-1->0 at end of frame.
REQ-014 Gaps in valid_in SHALL NOT change state; there is no backpressure.
REQ-015 Even row, even col: hold register h <= relu(pxl_in).
REQ-016 Even row, odd col: line buffer entry lb[col>>1] <= max(h, relu(pxl_in)); depth D/2 entries of data_width.
REQ-017 Odd row, even col: h <= max(lb[col>>1], relu(pxl_in)).
REQ-018 Odd row, odd col: pxl_out <= max(h, relu(pxl_in)) and valid_out <= 1 on the next rising edge (latency 1 cycle from the accepting edge).
REQ-019 For odd D, column D-1 and row D-1 SHALL be consumed by the counters but contribute to no output.
REQ-020 Each frame SHALL produce exactly floor(D/2)^2 outputs in raster order.
REQ-021 frame_end SHALL pulse with the output for window (floor(D/2)-1, floor(D/2)-1).
REQ-022 pxl_out SHALL hold its last value while valid_out is 0.
REQ-023 Back-to-back frames SHALL need no idle cycles; the pixel after row D-1, col D-1 is (0,0) of the next frame.

Reset
REQ-024 On reset assertion, col, row, valid_out, frame_end and pxl_out SHALL go to 0 immediately, without waiting for a clock edge.
REQ-025 h and lb contents are don't-care after reset, because each is written before it is read.
REQ-026 On reset mid-frame, the partial frame SHALL be discarded and the first valid_in after deassertion SHALL be treated as pixel (0,0).

Verification
REQ-027 D=4, pixels 1.0..16.0 in raster order (3F800000 step) -> outputs 40C00000, 41000000, 41600000, 41800000 (6, 8, 14, 16); frame_end with 41800000.
REQ-028 D=4, all pixels BF800000 (-1.0) -> four outputs of 00000000.
REQ-029 Repeat REQ-027 with valid_in high only every third cycle -> identical output values and order, each one cycle after the accepting edge.
REQ-030 D=4, assert reset after 5 pixels, then a full 1.0..16.0 frame -> exactly the four outputs of REQ-027 and no others.
REQ-031 D=5, pixels 1.0..25.0 -> four outputs 7.0, 9.0, 17.0, 19.0 (40E00000, 41100000, 41880000, 41980000); a second frame then yields the same four values.
REQ-032 D=4, pixel 0 = 7FC00000 (+NaN), others 1.0 -> first output 7FC00000; with FFC00000 (-NaN) instead, first output 3F800000.
